neuron_activate: RTL and testbench

NEURON_ACTIVATE -- requirements
Module: neuron_activate

---
 rtl/neuron_pkg.sv | 9 +
 rtl/sat_add32.sv | 15 +
 rtl/neuron_activate.sv | 80 ++++++++
 tb/tb_neuron_activate.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared FSM state type, fixed-point defaults and saturation limits for neuron_activate.
package neuron_pkg;
    typedef enum logic [1:0] {IDLE, ADD, ACT, DONE} state_e;
    localparam int FRAC_BITS_DEF = 16;
    localparam logic signed [31:0] ONE = 32'sd1 <<< FRAC_BITS_DEF;
    localparam logic signed [31:0] HALF = 32'sd1 <<< (FRAC_BITS_DEF - 1);
    localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;
endpackage

// File: rtl/sat_add32.sv
// sat_add32: combinational signed 32-bit add widened to 33 bits, clamped back to 32 with an overflow flag.
module sat_add32
    import neuron_pkg::*;
(
    input  logic signed [31:0] a_i,
    input  logic signed [31:0] b_i,
    output logic signed [31:0] y_o,
    output logic               ovf_o
);
    logic signed [32:0] s;
    assign s = {a_i[31], a_i} + {b_i[31], b_i};
    // The two top bits disagree exactly when the result does not fit in 32 bits.
    assign ovf_o = s[32] ^ s[31];
    assign y_o = ovf_o ? (s[32] ? SAT_MIN : SAT_MAX) : s[31:0];
endmodule

// File: rtl/neuron_activate.sv
// neuron_activate: bias add with saturation then activation (ReLU, or hard sigmoid when
// NEURON_SIGMOID_PWL_EN is defined); IDLE -> ADD -> ACT -> DONE, one result per 3 cycles.
module neuron_activate
    import neuron_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] sum,
    input  logic [31:0] bias,
    input  logic        start,
    output logic [31:0] out,
    output logic        sat,
    output logic        done
);
    state_e state_q, state_d;
    logic signed [31:0] sum_q, bias_q, x_q, add_y, act_d;
    logic [31:0] out_q;
    logic xsat_q, sat_q, add_ovf, load;

    sat_add32 u_add (
        .a_i  (sum_q),
        .b_i  (bias_q),
        .y_o  (add_y),
        .ovf_o(add_ovf)
    );

    assign load = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = (state_q == ADD) ? ACT :
                  (state_q == ACT) ? DONE :
                  load ? ADD : IDLE;
    end

`ifdef NEURON_SIGMOID_PWL_EN
    localparam logic signed [31:0] ONE_C = 32'sd1 <<< FRAC_BITS;
    localparam logic signed [31:0] HALF_C = 32'sd1 <<< (FRAC_BITS - 1);
    logic signed [31:0] t;
    always_comb begin
        t = (x_q >>> 2) + HALF_C;
        act_d = t[31] ? '0 : (t > ONE_C) ? ONE_C : t;
    end
`else
    always_comb begin
        act_d = x_q[31] ? '0 : x_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sum_q <= '0;
            bias_q <= '0;
            x_q <= '0;
            xsat_q <= 1'b0;
            out_q <= '0;
            sat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                sum_q <= sum;
                bias_q <= bias;
            end
            if (state_q == ADD) begin
                x_q <= add_y;
                xsat_q <= add_ovf;
            end
            if (state_q == ACT) begin
                out_q <= act_d;
                sat_q <= xsat_q;
            end
        end
    end

    assign out = out_q;
    assign sat = sat_q;
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_neuron_activate.sv
// tb_neuron_activate: directed checks of latency, saturation, activation, handshake and reset abort.
module tb_neuron_activate;
    logic clk = 1'b0;
    logic reset, start, sat, done;
    logic [31:0] sum, bias, out;
    int tests = 0;
    int fails = 0;

`ifdef NEURON_SIGMOID_PWL_EN
    localparam logic [31:0] E_BASIC = 32'h0001_0000;
    localparam logic [31:0] E_MAX = 32'h0001_0000;
    localparam logic [31:0] E_A = 32'h0000_C000;
    localparam logic [31:0] E_D = 32'h0001_0000;
    localparam logic [31:0] E_5 = 32'h0001_0000;
`else
    localparam logic [31:0] E_BASIC = 32'h0002_0000;
    localparam logic [31:0] E_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] E_A = 32'h0001_0000;
    localparam logic [31:0] E_D = 32'h0003_0000;
    localparam logic [31:0] E_5 = 32'h0005_0000;
`endif

    neuron_activate dut (
        .clk  (clk),
        .reset(reset),
        .sum  (sum),
        .bias (bias),
        .start(start),
        .out  (out),
        .sat  (sat),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [31:0] s, input logic [31:0] b, input logic [31:0] eo,
                      input logic es, input string tag);
        @(negedge clk);
        sum = s;
        bias = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sum = $urandom;
        bias = $urandom;
        chk({tag, "_done1"}, {31'b0, done}, 32'd0);
        @(negedge clk);
        chk({tag, "_done2"}, {31'b0, done}, 32'd0);
        @(negedge clk);
        chk({tag, "_done3"}, {31'b0, done}, 32'd1);
        chk({tag, "_out"}, out, eo);
        chk({tag, "_sat"}, {31'b0, sat}, {31'b0, es});
        @(negedge clk);
        chk({tag, "_done4"}, {31'b0, done}, 32'd0);
    endtask

    task automatic quiet(input string tag);
        repeat (4) begin
            @(negedge clk);
            chk({tag, "_nodone"}, {31'b0, done}, 32'd0);
        end
        chk({tag, "_out0"}, out, 32'd0);
        chk({tag, "_sat0"}, {31'b0, sat}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sum = '0;
        bias = '0;
        repeat (2) @(negedge clk);
        chk("rst_out", out, 32'd0);
        chk("rst_sat", {31'b0, sat}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;

        op(32'h0003_0000, 32'hFFFF_0000, E_BASIC, 1'b0, "basic");
        op(32'h7FFF_FFFF, 32'h0000_0001, E_MAX, 1'b1, "satpos");
        op(32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, "satneg");
`ifdef NEURON_SIGMOID_PWL_EN
        op(32'h0000_0000, 32'h0, 32'h0000_8000, 1'b0, "sig0");
        op(32'h0002_0000, 32'h0, 32'h0001_0000, 1'b0, "sig2");
        op(32'h0004_0000, 32'h0, 32'h0001_0000, 1'b0, "sig4");
        op(32'hFFFC_0000, 32'h0, 32'h0000_0000, 1'b0, "sigm4");
`endif

        // Second start in ADD is ignored; start in DONE is accepted.
        @(negedge clk);
        sum = 32'h0001_0000;
        bias = 32'h0;
        start = 1'b1;
        @(negedge clk);
        sum = 32'h0005_0000;
        chk("hs_add_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("hs_act_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("hs_done_a", {31'b0, done}, 32'd1);
        chk("hs_out_a", out, E_A);
        sum = 32'h0003_0000;
        bias = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hs_b2b_done1", {31'b0, done}, 32'd0);
        chk("hs_hold_out", out, E_A);
        @(negedge clk);
        chk("hs_b2b_done2", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("hs_done_d", {31'b0, done}, 32'd1);
        chk("hs_out_d", out, E_D);
        chk("hs_sat_d", {31'b0, sat}, 32'd0);
        @(negedge clk);
        chk("hs_idle_done", {31'b0, done}, 32'd0);
        chk("hs_hold_out2", out, E_D);

        // Reset during ADD.
        @(negedge clk);
        sum = 32'h0005_0000;
        bias = 32'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        quiet("rst_add");
        op(32'h0005_0000, 32'h0, E_5, 1'b0, "post_rst_add");

        // Reset during ACT.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        quiet("rst_act");
        op(32'h0005_0000, 32'h0, E_5, 1'b0, "post_rst_act");

        // Start coinciding with reset is discarded.
        @(negedge clk);
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        quiet("rst_start");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
